// File: rtl/mac_header_inserter_if.sv
// AXI4-Stream bundle used on both sides of the header inserter.
// Master drives payload and valid; slave drives ready.
interface mac_header_inserter_if #(
    parameter int DW = 512,
    parameter int UW = 256
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (
        output tdata,
        output tkeep,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/mac_header_inserter.sv
// Prepends a 14-byte Ethernet II header to each payload frame.
// Payload is shifted up by 14 bytes; a tail overflow gets a flush beat.
module mac_header_inserter #(
    parameter int          AXIS_DATA_WIDTH  = 512,
    parameter int          AXIS_TUSER_WIDTH = 256,
    parameter logic [15:0] TYPE             = 16'h0800
) (
    input  logic                  axis_aclk,
    input  logic                  axis_resetn,
    input  logic [47:0]           dest_mac_addr,
    input  logic [47:0]           src_mac_addr,
    mac_header_inserter_if.slave  s_axis,
    mac_header_inserter_if.master m_axis
);
    localparam int DW = AXIS_DATA_WIDTH;
    localparam int UW = AXIS_TUSER_WIDTH;
    localparam int KB = DW / 8;
    localparam int H  = 14;
    localparam int R  = KB - H;

    typedef enum logic [1:0] {
        HEAD  = 2'd0,
        BODY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [H*8-1:0]  resid_data;
    logic [H-1:0]    resid_keep;
    logic [UW-1:0]   hdr_tuser;

    logic [H*8-1:0]  hdr;
    logic [UW-1:0]   tuser_adj;
    logic            s_ready;
    logic            m_valid;
    logic            s_xfer;
    logic            m_xfer;
    logic            ovf;

    assign tuser_adj = {s_axis.tuser[UW-1:16],
                        s_axis.tuser[15:0] + 16'd14};
    assign s_xfer    = s_axis.tvalid && s_ready;
    assign m_xfer    = m_valid && m_axis.tready;
    assign ovf       = s_axis.tkeep[R];

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;

    // Header bytes in wire order: dest MAC, src MAC, EtherType.
    always_comb begin
        hdr = '0;
        for (int i = 0; i < 6; i++) begin
            hdr[8*i +: 8]     = dest_mac_addr[8*(5-i) +: 8];
            hdr[8*(6+i) +: 8] = src_mac_addr[8*(5-i) +: 8];
        end
        hdr[8*12 +: 8] = TYPE[15:8];
        hdr[8*13 +: 8] = TYPE[7:0];
    end

    // State register.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= HEAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: advance on each accepted beat, flush on tail overflow.
    always_comb begin
        state_nx = state;
        unique case (state)
            HEAD, BODY: begin
                if (s_xfer) begin
                    if (!s_axis.tlast) begin
                        state_nx = BODY;
                    end else if (ovf) begin
                        state_nx = FLUSH;
                    end else begin
                        state_nx = HEAD;
                    end
                end
            end
            FLUSH: begin
                if (m_xfer) begin
                    state_nx = HEAD;
                end
            end
            default: state_nx = HEAD;
        endcase
    end

    // Outputs: pass-through with a 14-byte shift, or the held tail.
    always_comb begin
        m_axis.tdata = '0;
        m_axis.tkeep = '0;
        m_axis.tuser = '0;
        m_axis.tlast = 1'b0;
        m_valid      = 1'b0;
        s_ready      = 1'b0;
        unique case (state)
            HEAD, BODY: begin
                m_valid = s_axis.tvalid;
                s_ready = m_axis.tready;
                if (state == HEAD) begin
                    m_axis.tdata = {s_axis.tdata[R*8-1:0], hdr};
                    m_axis.tuser = tuser_adj;
                end else begin
                    m_axis.tdata = {s_axis.tdata[R*8-1:0], resid_data};
                    m_axis.tuser = hdr_tuser;
                end
                if (s_axis.tlast && !ovf) begin
                    m_axis.tkeep = {s_axis.tkeep[R-1:0], {H{1'b1}}};
                    m_axis.tlast = 1'b1;
                end else begin
                    m_axis.tkeep = '1;
                    m_axis.tlast = 1'b0;
                end
            end
            FLUSH: begin
                m_valid      = 1'b1;
                s_ready      = 1'b0;
                m_axis.tdata = {{(DW-H*8){1'b0}}, resid_data};
                m_axis.tkeep = {{R{1'b0}}, resid_keep};
                m_axis.tuser = hdr_tuser;
                m_axis.tlast = 1'b1;
            end
            default: begin
                m_valid = 1'b0;
                s_ready = 1'b0;
            end
        endcase
    end

    // Capture the top 14 bytes of each accepted beat and the frame tuser.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            resid_data <= '0;
            resid_keep <= '0;
            hdr_tuser  <= '0;
        end else if (s_xfer && state != FLUSH) begin
            resid_data <= s_axis.tdata[DW-1 -: H*8];
            resid_keep <= s_axis.tkeep[KB-1 -: H];
            if (state == HEAD) begin
                hdr_tuser <= tuser_adj;
            end
        end
    end
endmodule

// File: tb/tb_mac_header_inserter.sv
// Randomized bench for mac_header_inserter with a byte-level reference.
// Expected beats come from header ++ payload chopped into bus words.
module tb_mac_header_inserter;
    localparam int DW = 512;
    localparam int UW = 256;
    localparam int KB = DW / 8;
    localparam int H  = 14;

    typedef struct {
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        logic          flush;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] dest = '0;
    logic [47:0] src = '0;

    mac_header_inserter_if #(.DW(DW), .UW(UW)) s_if ();
    mac_header_inserter_if #(.DW(DW), .UW(UW)) m_if ();

    mac_header_inserter #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_TUSER_WIDTH(UW),
        .TYPE            (16'h0800)
    ) dut (
        .axis_aclk    (clk),
        .axis_resetn  (rst_n),
        .dest_mac_addr(dest),
        .src_mac_addr (src),
        .s_axis       (s_if),
        .m_axis       (m_if)
    );

    always #5 clk = ~clk;

    beat_t         exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    bit            mon_en = 1'b0;
    int            rdy_mode = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] held_data;
    logic [KB-1:0] held_keep;

    task automatic check(string tag, logic [DW-1:0] got,
                         logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sink ready pattern: always, random, or toggling.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_if.tready = ($urandom_range(0, 3) != 0);
                2:       m_if.tready = ~m_if.tready;
                default: m_if.tready = 1'b1;
            endcase
        end
    end

    // Output monitor: compare each accepted beat and stall stability.
    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_if.tvalid) begin
                check("hold_data", m_if.tdata, held_data);
                check("hold_keep", DW'(m_if.tkeep), DW'(held_keep));
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            held_data  = m_if.tdata;
            held_keep  = m_if.tkeep;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", exp_q.size(), 1);
                end else begin
                    beat_t         e;
                    logic [DW-1:0] mask;
                    e = exp_q.pop_front();
                    for (int k = 0; k < KB; k++) begin
                        mask[8*k +: 8] = {8{e.keep[k]}};
                    end
                    check("data", m_if.tdata & mask, e.data);
                    check("keep", DW'(m_if.tkeep), DW'(e.keep));
                    check("user", DW'(m_if.tuser), DW'(e.user));
                    check("last", DW'(m_if.tlast), DW'(e.last));
                    if (e.flush) begin
                        check("flush_srdy", DW'(s_if.tready), 0);
                    end
                end
            end
        end
    end

    // Build the expected output beats, then drive up to max_beats beats.
    task automatic send_frame(int len, logic [15:0] lfield,
                              logic [47:0] d, logic [47:0] s,
                              int max_beats);
        byte unsigned  pl[$];
        byte unsigned  ob[$];
        logic [UW-1:0] u;
        int            nin;
        int            nout;
        for (int i = 0; i < len; i++) begin
            pl.push_back(8'($urandom));
        end
        for (int w = 0; w < UW / 32; w++) begin
            u[32*w +: 32] = $urandom;
        end
        u[15:0] = lfield;
        for (int i = 0; i < 6; i++) ob.push_back(d[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) ob.push_back(s[8*(5-i) +: 8]);
        ob.push_back(8'h08);
        ob.push_back(8'h00);
        foreach (pl[i]) ob.push_back(pl[i]);
        nin  = (len == 0) ? 1 : (len + KB - 1) / KB;
        nout = (ob.size() + KB - 1) / KB;
        for (int b = 0; b < nout; b++) begin
            beat_t e;
            e.data = '0;
            e.keep = '0;
            for (int k = 0; k < KB; k++) begin
                if (b * KB + k < ob.size()) begin
                    e.data[8*k +: 8] = ob[b*KB + k];
                    e.keep[k] = 1'b1;
                end
            end
            e.user  = {u[UW-1:16], lfield + 16'd14};
            e.last  = (b == nout - 1);
            e.flush = (b == nout - 1) && (nout > nin);
            exp_q.push_back(e);
        end
        dest = d;
        src  = s;
        for (int b = 0; b < nin && b < max_beats; b++) begin
            bit hs;
            repeat ($urandom_range(0, 2)) begin
                s_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < KB; k++) begin
                int idx;
                idx = b * KB + k;
                s_if.tdata[8*k +: 8] = (idx < len) ? pl[idx]
                                                   : 8'($urandom);
                s_if.tkeep[k] = (idx < len);
            end
            for (int w = 0; w < UW / 32; w++) begin
                s_if.tuser[32*w +: 32] = $urandom;
            end
            if (b == 0) s_if.tuser = u;
            s_if.tlast  = (b == nin - 1);
            s_if.tvalid = 1'b1;
            hs = 1'b0;
            for (int c = 0; c < 2000 && !hs; c++) begin
                @(negedge clk);
                hs = s_if.tready;
                @(posedge clk);
                #1;
            end
            check("s_hs", DW'(hs), 1);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) begin
            @(posedge clk);
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    function automatic logic [47:0] rnd_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mvalid", DW'(m_if.tvalid), 0);
        check("rst_srdy", DW'(s_if.tready), 1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        send_frame(46, 16'd46, 48'h020000000001, 48'h020000000002, 99);
        send_frame(64, 16'd64, rnd_mac(), rnd_mac(), 99);
        send_frame(114, 16'd114, rnd_mac(), rnd_mac(), 99);
        send_frame(150, 16'h0040, rnd_mac(), rnd_mac(), 99);
        send_frame(60, 16'hFFF8, rnd_mac(), rnd_mac(), 99);
        send_frame(0, 16'd0, rnd_mac(), rnd_mac(), 99);
        send_frame(50, 16'd50, rnd_mac(), rnd_mac(), 99);
        send_frame(51, 16'd51, rnd_mac(), rnd_mac(), 99);
        wait_drain();

        rdy_mode = 2;
        send_frame(200, 16'd200, rnd_mac(), rnd_mac(), 99);
        send_frame(250, 16'd250, rnd_mac(), rnd_mac(), 99);
        wait_drain();

        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(0, 300);
            send_frame(len, 16'(len), rnd_mac(), rnd_mac(), 99);
        end
        wait_drain();

        rdy_mode = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        send_frame(64, 16'd64, rnd_mac(), rnd_mac(), 99);
        rst_n = 1'b0;
        #1;
        check("rstf_mvalid", DW'(m_if.tvalid), 0);
        check("rstf_srdy", DW'(s_if.tready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        send_frame(20, 16'd20, rnd_mac(), rnd_mac(), 99);
        wait_drain();

        mon_en = 1'b0;
        send_frame(180, 16'd180, rnd_mac(), rnd_mac(), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        send_frame(30, 16'd30, rnd_mac(), rnd_mac(), 99);
        send_frame(120, 16'd120, rnd_mac(), rnd_mac(), 99);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
